// File: rtl/axis_mt19937_checker.sv
// AXI4-Stream sink that validates an MT19937 output stream.
// It untempers the first 624 accepted words to rebuild the generator state,
// then predicts each following word and pulses `mismatch` on a difference.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   input_axis_*        32-bit stream sink (tdata/tvalid/tready)
//   locked              state rebuilt, checking active
//   mismatch            one-cycle pulse after a checked word differs
//   error_count         saturating count of mismatching words
//   word_count          saturating count of accepted words
//   busy                high outside COLLECT
//   resync              one-cycle request to restart collection
module axis_mt19937_checker #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          input_axis_tdata,
  input  logic                 input_axis_tvalid,
  output logic                 input_axis_tready,
  output logic                 locked,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  input  logic                 resync
);

  localparam logic [9:0] LAST_IDX = 10'd623;
  localparam logic [9:0] N_WORDS  = 10'd624;
  localparam logic [9:0] M_OFF    = 10'd397;

  typedef enum logic [1:0] {COLLECT, FETCH, CHECK} state_e;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 11);
    y = y ^ ((y << 7) & 32'h9d2c5680);
    y = y ^ ((y << 15) & 32'hefc60000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  function automatic logic [31:0] untemper(input logic [31:0] x);
    logic [31:0] y;
    logic [31:0] z;
    y = x ^ (x >> 18);
    y = y ^ ((y << 15) & 32'hefc60000);
    // Fixed-point inversion of y ^= (y<<7)&mask: each pass re-applies the
    // masked shift of the running value to the step's input; 4 passes cover
    // all 32 bits.
    z = y;
    for (int unsigned k = 0; k < 4; k++) begin
      z = y ^ ((z << 7) & 32'h9d2c5680);
    end
    return z ^ (z >> 11) ^ (z >> 22);
  endfunction

  state_e               state_q, state_d;
  logic [9:0]           index_q, index_d;
  logic                 locked_q, locked_d;
  logic                 mismatch_q, mismatch_d;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  logic [CNT_WIDTH-1:0] wc_q, wc_d;

  logic [31:0] mt_mem [0:623];
  logic [31:0] mt_i_q, mt_i1_q, mt_m_q;

  logic        accept;
  logic [9:0]  idx_p1, idx_m, idx_sum;
  logic [31:0] y_mix, n_pred, p_pred;
  logic        mem_we;
  logic [31:0] mem_wdata;

  always_comb begin
    idx_p1  = (index_q == LAST_IDX) ? '0 : index_q + 10'd1;
    idx_sum = index_q + M_OFF;
    idx_m   = (idx_sum >= N_WORDS) ? idx_sum - N_WORDS : idx_sum;
  end

  always_comb begin
    y_mix  = {mt_i_q[31], mt_i1_q[30:0]};
    n_pred = mt_m_q ^ (y_mix >> 1) ^ (y_mix[0] ? 32'h9908b0df : '0);
    p_pred = temper(n_pred);
  end

  assign input_axis_tready = (state_q != FETCH);
  assign accept            = input_axis_tvalid && input_axis_tready;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    locked_d   = locked_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    wc_d       = wc_q;
    mem_we     = 1'b0;
    mem_wdata  = untemper(input_axis_tdata);
    if (resync) begin
      // The word accepted alongside resync is dropped entirely.
      state_d  = COLLECT;
      index_d  = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            mem_we = 1'b1;
            wc_d   = (wc_q == '1) ? wc_q : wc_q + CNT_WIDTH'(1);
            if (index_q == LAST_IDX) begin
              index_d  = '0;
              locked_d = 1'b1;
              state_d  = FETCH;
            end else begin
              index_d = index_q + 10'd1;
            end
          end
        end
        FETCH: begin
          state_d = CHECK;
        end
        CHECK: begin
          if (accept) begin
            // Store the prediction, not the received word, so one corrupted
            // word cannot poison later predictions.
            mem_we    = 1'b1;
            mem_wdata = n_pred;
            wc_d      = (wc_q == '1) ? wc_q : wc_q + CNT_WIDTH'(1);
            index_d   = idx_p1;
            if (input_axis_tdata != p_pred) begin
              mismatch_d = 1'b1;
              err_d      = (err_q == '1) ? err_q : err_q + CNT_WIDTH'(1);
            end
            state_d = FETCH;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      index_q    <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      wc_q       <= wc_d;
    end
  end

  // State RAM: single write port, three registered reads loaded only in
  // FETCH, so the holding registers stay put while CHECK waits for data.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mt_mem[index_q] <= mem_wdata;
    end
    if (state_q == FETCH) begin
      mt_i_q  <= mt_mem[index_q];
      mt_i1_q <= mt_mem[idx_p1];
      mt_m_q  <= mt_mem[idx_m];
    end
  end

  assign locked      = locked_q;
  assign mismatch    = mismatch_q;
  assign error_count = err_q;
  assign word_count  = wc_q;
  assign busy        = (state_q != COLLECT);

endmodule
